// File: rtl/manual_drive_fsm_if.sv
// Driver switch inputs and car state outputs of the manual drive controller.
// master drives the switches, slave is the controller.
interface manual_drive_fsm_if #(
   parameter int ODO_W = 16
);
   logic             power_on_btn;
   logic             power_off_btn;
   logic             throttle;
   logic             clutch;
   logic             brake;
   logic             reverse_sw;
   logic             turn_left_sw;
   logic             turn_right_sw;
   logic [3:0]       state;
   logic [3:0]       answer;
   logic             power_now;
   logic [ODO_W-1:0] odometer;

   modport master (
      output power_on_btn, power_off_btn,
      output throttle, clutch, brake,
      output reverse_sw, turn_left_sw, turn_right_sw,
      input  state, answer, power_now, odometer
   );

   modport slave (
      input  power_on_btn, power_off_btn,
      input  throttle, clutch, brake,
      input  reverse_sw, turn_left_sw, turn_right_sw,
      output state, answer, power_now, odometer
   );
endinterface

// File: rtl/manual_drive_fsm.sv
// Manual-transmission drive controller on the 2 Hz tick:
// one-hot car state, drive command vector and a half-second odometer.
module manual_drive_fsm #(
   parameter int ON_HOLD = 2,
   parameter int ODO_W   = 16
) (
   input logic              clk_2hz,
   input logic              rst,
   manual_drive_fsm_if.slave bus
);
   typedef enum logic [3:0] {
      NOT_STARTING = 4'b0001,
      STARTING     = 4'b0010,
      MOVING       = 4'b0100,
      OFF          = 4'b1000
   } state_t;

   localparam int HW = (ON_HOLD > 1) ? $clog2(ON_HOLD) : 1;
   localparam logic [HW-1:0] HOLD_M1 = HW'(ON_HOLD - 1);
   localparam logic [ODO_W-1:0] ODO_MAX = {ODO_W{1'b1}};

   state_t           state_q;
   state_t           nxt;
   logic [HW-1:0]    hold_q;
   logic [HW-1:0]    hold_nxt;
   logic             rev_q;
   logic             rev_chg;
   logic             turn_ok;
   logic [3:0]       ans_nxt;
   logic [3:0]       ans_q;
   logic             pwr_q;
   logic [ODO_W-1:0] odo_q;

   always_comb begin
      nxt      = state_q;
      hold_nxt = '0;
      rev_chg  = bus.reverse_sw != rev_q;
      if (state_q != OFF && bus.power_off_btn) begin
         nxt = OFF;
      end else begin
         unique case (state_q)
            OFF: begin
               if (bus.power_on_btn) begin
                  if (hold_q == HOLD_M1) nxt = NOT_STARTING;
                  else hold_nxt = hold_q + HW'(1);
               end
            end
            NOT_STARTING: begin
               if (bus.throttle && bus.clutch) nxt = STARTING;
               else if (bus.throttle) nxt = OFF;
            end
            STARTING: begin
               if (bus.brake) nxt = NOT_STARTING;
               else if (bus.throttle && !bus.clutch) nxt = MOVING;
            end
            MOVING: begin
               // shifting gear without the clutch stalls the engine
               if (rev_chg && !bus.clutch) nxt = OFF;
               else if (bus.brake) nxt = NOT_STARTING;
               else if (bus.clutch || !bus.throttle) nxt = STARTING;
            end
            default: nxt = OFF;
         endcase
      end
   end

   always_comb begin
      turn_ok = (nxt == STARTING) || (nxt == MOVING);
      ans_nxt = {
         turn_ok & bus.turn_left_sw & ~bus.turn_right_sw,
         turn_ok & bus.turn_right_sw & ~bus.turn_left_sw,
         (nxt == MOVING) & bus.reverse_sw,
         (nxt == MOVING) & ~bus.reverse_sw
      };
   end

   always_ff @(posedge clk_2hz or negedge rst) begin
      if (!rst) begin
         state_q <= OFF;
         hold_q  <= '0;
         rev_q   <= 1'b0;
         ans_q   <= 4'b0000;
         pwr_q   <= 1'b1;
         odo_q   <= '0;
      end else begin
         state_q <= nxt;
         hold_q  <= hold_nxt;
         rev_q   <= bus.reverse_sw;
         ans_q   <= ans_nxt;
         pwr_q   <= (nxt == OFF);
         if (state_q == MOVING && odo_q != ODO_MAX)
            odo_q <= odo_q + ODO_W'(1);
      end
   end

   assign bus.state     = state_q;
   assign bus.answer    = ans_q;
   assign bus.power_now = pwr_q;
   assign bus.odometer  = odo_q;
endmodule

// File: tb/tb_manual_drive_fsm.sv
// Directed and randomized bench for manual_drive_fsm against
// a mode-level reference model of the drive rules.
`timescale 1ns/1ps
module tb_manual_drive_fsm;
   localparam int ON_HOLD = 2;
   localparam int ODO_W   = 4;
   localparam int ODO_MAX = (1 << ODO_W) - 1;
   localparam int M_NS  = 0;
   localparam int M_ST  = 1;
   localparam int M_MV  = 2;
   localparam int M_OFF = 3;

   logic clk_2hz = 1'b0;
   logic rst     = 1'b0;

   manual_drive_fsm_if #(.ODO_W(ODO_W)) bus ();

   manual_drive_fsm #(.ON_HOLD(ON_HOLD), .ODO_W(ODO_W)) dut (
      .clk_2hz(clk_2hz),
      .rst    (rst),
      .bus    (bus)
   );

   always #5 clk_2hz = ~clk_2hz;

   int n_tests = 0;
   int n_fail  = 0;

   int m_mode;
   int m_hold;
   int m_rev;
   int m_odo;
   int m_ans;
   int m_pwr;

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = M_OFF;
      m_hold = 0;
      m_rev  = 0;
      m_odo  = 0;
      m_ans  = 0;
      m_pwr  = 1;
   endtask

   task automatic model_step();
      int nx;
      int l;
      int r;
      int rv;
      rv = int'(bus.reverse_sw);
      nx = m_mode;
      if (m_mode == M_MV && m_odo < ODO_MAX) m_odo++;
      if (m_mode != M_OFF && bus.power_off_btn) begin
         nx = M_OFF;
      end else if (m_mode == M_OFF) begin
         if (bus.power_on_btn) begin
            if (m_hold + 1 >= ON_HOLD) begin
               nx = M_NS;
               m_hold = 0;
            end else begin
               m_hold++;
            end
         end else begin
            m_hold = 0;
         end
      end else if (m_mode == M_NS) begin
         if (bus.throttle) nx = bus.clutch ? M_ST : M_OFF;
      end else if (m_mode == M_ST) begin
         if (bus.brake) nx = M_NS;
         else if (bus.throttle && !bus.clutch) nx = M_MV;
      end else begin
         if (rv != m_rev && !bus.clutch) nx = M_OFF;
         else if (bus.brake) nx = M_NS;
         else if (bus.clutch || !bus.throttle) nx = M_ST;
      end
      if (nx != M_OFF) m_hold = 0;
      m_ans = 0;
      if (nx == M_ST || nx == M_MV) begin
         l = int'(bus.turn_left_sw);
         r = int'(bus.turn_right_sw);
         if (l == 1 && r == 0) m_ans += 8;
         if (r == 1 && l == 0) m_ans += 4;
         if (nx == M_MV) m_ans += (rv == 1) ? 2 : 1;
      end
      m_pwr  = (nx == M_OFF) ? 1 : 0;
      m_rev  = rv;
      m_mode = nx;
   endtask

   task automatic check_all(input string tag);
      check({tag, ".state"}, 32'(bus.state), 32'(1 << m_mode));
      check({tag, ".answer"}, 32'(bus.answer), 32'(m_ans));
      check({tag, ".power"}, 32'(bus.power_now), 32'(m_pwr));
      check({tag, ".odo"}, 32'(bus.odometer), 32'(m_odo));
   endtask

   task automatic step(input string tag);
      @(posedge clk_2hz);
      model_step();
      #1;
      check_all(tag);
      @(negedge clk_2hz);
   endtask

   task automatic clear_in();
      bus.power_on_btn  = 1'b0;
      bus.power_off_btn = 1'b0;
      bus.throttle      = 1'b0;
      bus.clutch        = 1'b0;
      bus.brake         = 1'b0;
      bus.reverse_sw    = 1'b0;
      bus.turn_left_sw  = 1'b0;
      bus.turn_right_sw = 1'b0;
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b0;
      #1;
      model_reset();
      check_all(tag);
      @(negedge clk_2hz);
      rst = 1'b1;
   endtask

   task automatic power_up();
      bus.power_on_btn = 1'b1;
      step("pwr_on1");
      step("pwr_on2");
      bus.power_on_btn = 1'b0;
   endtask

   task automatic to_moving();
      bus.throttle = 1'b1;
      bus.clutch   = 1'b1;
      step("to_st");
      bus.clutch = 1'b0;
      step("to_mv");
   endtask

   initial begin
      clear_in();
      model_reset();
      @(negedge clk_2hz);
      do_reset("reset");

      bus.power_on_btn = 1'b1;
      step("short1");
      bus.power_on_btn = 1'b0;
      step("short2");
      check("short_state", 32'(bus.state), 32'h8);
      check("short_power", 32'(bus.power_now), 32'h1);

      power_up();
      check("on_state", 32'(bus.state), 32'h1);
      check("on_power", 32'(bus.power_now), 32'h0);

      to_moving();
      check("fwd_answer", 32'(bus.answer), 32'h1);
      bus.reverse_sw = 1'b1;
      bus.clutch     = 1'b1;
      step("rev_clutch");
      check("rev_cl_state", 32'(bus.state), 32'h2);
      bus.clutch = 1'b0;
      step("rev_go");
      check("back_answer", 32'(bus.answer), 32'h2);
      bus.reverse_sw = 1'b0;
      step("shift_stall");
      check("shift_state", 32'(bus.state), 32'h8);

      clear_in();
      power_up();
      bus.throttle = 1'b1;
      step("stall");
      check("stall_state", 32'(bus.state), 32'h8);

      clear_in();
      power_up();
      to_moving();
      bus.turn_left_sw = 1'b1;
      step("left");
      check("left_answer", 32'(bus.answer), 32'h9);
      bus.turn_right_sw = 1'b1;
      step("both");
      check("both_answer", 32'(bus.answer), 32'h1);
      bus.brake = 1'b1;
      step("brake");
      check("brake_state", 32'(bus.state), 32'h1);
      check("brake_answer", 32'(bus.answer), 32'h0);

      clear_in();
      @(negedge clk_2hz);
      do_reset("reset2");
      power_up();
      to_moving();
      for (int i = 0; i < 5; i++) step("odo5");
      check("odo_5", 32'(bus.odometer), 32'd5);
      for (int i = 0; i < 15; i++) step("odo20");
      check("odo_sat", 32'(bus.odometer), 32'd15);
      clear_in();
      bus.power_off_btn = 1'b1;
      step("odo_off");
      bus.power_off_btn = 1'b0;
      power_up();
      check("odo_keep", 32'(bus.odometer), 32'd15);
      do_reset("odo_rst");
      check("odo_clr", 32'(bus.odometer), 32'd0);

      power_up();
      bus.throttle = 1'b1;
      bus.clutch   = 1'b1;
      step("pri_st");
      bus.clutch        = 1'b0;
      bus.power_off_btn = 1'b1;
      step("pri_off");
      check("pri_state", 32'(bus.state), 32'h8);

      clear_in();
      power_up();
      to_moving();
      #2;
      do_reset("async_rst");
      check("async_state", 32'(bus.state), 32'h8);

      for (int i = 0; i < 600; i++) begin
         bus.power_on_btn  = ($urandom_range(3) != 0);
         bus.power_off_btn = ($urandom_range(15) == 0);
         bus.throttle      = ($urandom_range(3) != 0);
         bus.clutch        = ($urandom_range(2) == 0);
         bus.brake         = ($urandom_range(7) == 0);
         if ($urandom_range(5) == 0) bus.reverse_sw = ~bus.reverse_sw;
         bus.turn_left_sw  = ($urandom_range(2) == 0);
         bus.turn_right_sw = ($urandom_range(2) == 0);
         if ($urandom_range(149) == 0) begin
            #2;
            do_reset("rnd_rst");
         end else begin
            step("rnd");
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/manual_drive_fsm.md
# manual_drive_fsm

Manual-transmission drive controller for the car. It runs on the 2 Hz tick and turns the driver's switches (power buttons, throttle, clutch, brake, reverse, turn switches) into the one-hot car state, the `{left, right, back, forward}` command vector and the powered-off flag. These outputs are consumed directly by the turn-light stage and the motion/display stages, and the block also keeps a half-second odometer.

## Interface
Parameters:
- `ON_HOLD`, default 2: consecutive `clk_2hz` edges `power_on_btn` must be sampled high to power on (2 = 1 s).
- `ODO_W`, default 16: odometer width.

Ports:
- `clk_2hz`  in  1  2 Hz clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `power_on_btn`  in  1  power-on button, level, synchronous to `clk_2hz`.
- `power_off_btn`  in  1  power-off button.
- `throttle`  in  1  throttle switch.
- `clutch`  in  1  clutch switch.
- `brake`  in  1  brake switch.
- `reverse_sw`  in  1  gear: 1 = reverse, 0 = forward.
- `turn_left_sw`  in  1  left turn switch.
- `turn_right_sw`  in  1  right turn switch.
- `state`  out  4  one-hot: 0001 NOT_STARTING, 0010 STARTING, 0100 MOVING, 1000 OFF.
- `answer`  out  4  `{left, right, back, forward}` command.
- `power_now`  out  1  1 while `state` = OFF.
- `odometer`  out  `ODO_W`  half-second ticks spent in MOVING.

## Operation
- Reset (rst=0): `state`=1000, `answer`=0000, `power_now`=1, `odometer`=0, hold counter=0, `rev_q`=0.
- `rev_q` registers `reverse_sw` every edge. A reverse change means `reverse_sw != rev_q`.
- Transitions are evaluated in priority order; the first match wins.
  - Any powered state (not OFF): `power_off_btn`=1 -> OFF.
  - OFF: hold counter increments while `power_on_btn`=1 and clears to 0 when it is 0. When counter+1 reaches `ON_HOLD`, go to NOT_STARTING and clear the counter. The counter is also cleared in every non-OFF state.
  - NOT_STARTING: `throttle` & `clutch` -> STARTING. `throttle` & !`clutch` -> OFF (stall). Otherwise stay.
  - STARTING: `brake` -> NOT_STARTING. `throttle` & !`clutch` -> MOVING. Otherwise stay.
  - MOVING: reverse change & !`clutch` -> OFF (gear shift without clutch). `brake` -> NOT_STARTING. `clutch` or !`throttle` -> STARTING. Otherwise stay.
- `answer` is registered from the next state and the current inputs.
  - left = nextSTARTING/MOVING & `turn_left_sw` & !`turn_right_sw`.
  - right = same condition, mirrored.
  - Both turn switches set -> left=right=0.
  - back = next is MOVING & `reverse_sw`. forward = next is MOVING & !`reverse_sw`.
  - Next state OFF or NOT_STARTING -> `answer`=0000.
- `power_now` is registered as (next state == OFF).
- `odometer` increments on each edge where the current `state` is MOVING. It saturates at all-ones and is cleared only by `rst`; it holds through OFF.

## Timing
- All outputs are registered. An input sampled at edge N is reflected in the outputs immediately after edge N (latency 1 edge, 0.5 s max).
- Power-on with `ON_HOLD`=2: button high at edges N and N+1 -> `state`=0001 after N+1. Releasing the button before N+1 restarts the count.
- `power_off_btn` overrides every other input in the same edge. In OFF it is ignored and `power_on_btn` still counts.
- Reset is asynchronous: asserting `rst` mid-MOVING forces all outputs to their reset values without waiting for an edge. Release takes effect at the next edge.
- `state` is always exactly one-hot. The 4'b0000 code never appears.

## Test plan
- Reset, then `power_on_btn`=1 for 1 edge, then 0 -> `state` stays 1000, `power_now`=1. Hold it 2 edges -> `state`=0001, `power_now`=0.
- From 0001, `throttle`=1, `clutch`=1 -> 0010. Then `clutch`=0 -> 0100 with `answer`=0001. Then `reverse_sw`=1 with `clutch`=1 -> 0010, `answer`=0000. Then release `clutch` -> 0100 with `answer`=0010.
- In 0100, toggle `reverse_sw` with `clutch`=0 -> 1000, `answer`=0000, `power_now`=1. In 0001, `throttle`=1 with `clutch`=0 -> 1000 (stall).
- In 0100, `turn_left_sw`=1 -> `answer`=1001. Both turn switches set -> 0001. `brake`=1 -> `state`=0001, `answer`=0000.
- Stay in MOVING for 5 edges -> `odometer`=5. With `ODO_W`=4, stay 20 edges -> 15 (saturated). Power off and back on -> value retained. `rst`=0 -> 0.
- In 0010 with `throttle`=1, `clutch`=0, `power_off_btn`=1 on the same edge -> 1000. Assert `rst` between edges while in MOVING -> outputs reset immediately.
